// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// line-level helper used by the transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int   CLKS_PER_BIT_DEFAULT = 10416;
  localparam int   FRAME_BITS           = 10;
  localparam logic LINE_IDLE            = 1'b1;
  localparam logic LINE_START           = 1'b0;
  localparam logic LINE_STOP            = 1'b1;

  // Serial line level for a given state; data_bit is only used in ST_DATA.
  function automatic logic line_level(input uart_state_e st, input logic data_bit);
    logic lvl;
    case (st)
      ST_IDLE:  lvl = LINE_IDLE;
      ST_START: lvl = LINE_START;
      ST_DATA:  lvl = data_bit;
      ST_STOP:  lvl = LINE_STOP;
      default:  lvl = LINE_IDLE;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_tx_top_baud.sv
// Full-bit-period baud counter for the transmitter: counts 0..CLKS_PER_BIT-1
// while enabled, is held at zero otherwise, and flags the last cycle of a bit.
module tx_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic tx_rst,
  input  logic enable,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  // Next count: wrap on the last cycle of the bit, hold at zero when idle.
  always_comb begin
    w_count_next = '0;
    if (!enable) begin
      w_count_next = '0;
    end else if (r_count == LAST_CNT) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (tx_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign bit_tick = (r_count == LAST_CNT);

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: serialises one byte per accepted start strobe as an 8N1
// frame. All outputs come straight from registers.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 tx_rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

  uart_state_e          r_state;
  uart_state_e          w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_bit_idx_next;
  logic                 w_done_next;
  logic                 r_tx_out;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_bit_tick;
  logic                 w_baud_en;

  assign w_baud_en = (r_state != ST_IDLE);

  tx_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .tx_rst   (tx_rst),
    .enable   (w_baud_en),
    .bit_tick (w_bit_tick)
  );

  // Next-state, shift register and bit index logic.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_done_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_state_next   = ST_START;
          w_shift_next   = tx_data;
          w_bit_idx_next = '0;
        end else begin
          w_state_next   = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_tick) begin
          w_state_next = ST_DATA;
        end else begin
          w_state_next = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_tick) begin
          if (r_bit_idx == LAST_IDX) begin
            w_state_next = ST_STOP;
          end else begin
            w_state_next   = ST_DATA;
            w_shift_next   = r_shift >> 1'b1;
            w_bit_idx_next = r_bit_idx + IDX_ONE;
          end
        end else begin
          w_state_next = ST_DATA;
        end
      end
      ST_STOP: begin
        if (w_bit_tick) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so the line changes on the
  // same edge the FSM moves, keeping them registered without extra latency.
  always_ff @(posedge clk) begin
    if (tx_rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx_out  <= LINE_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx_out  <= line_level(w_state_next, w_shift_next[0]);
      r_busy    <= (w_state_next != ST_IDLE);
      r_done    <= w_done_next;
    end
  end

  assign tx_out  = r_tx_out;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

Transmit half of the UART: accepts one parallel byte on a single-cycle start strobe and serialises it as an 8N1 frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held for a fixed number of clock cycles (default 10416 = 9600 baud at 100 MHz). It sits between the user/byte-source logic and the TX pin and is timing-compatible with the receive path's bit period.

## Interface
Parameters:
- CLKS_PER_BIT, 10416, clock cycles per serial bit; minimum 2.
- DATA_BITS, 8, payload bits per frame.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- tx_rst  in  1  reset; synchronous, active-high.
- tx_start  in  1  request to send `tx_data`; sampled only when idle.
- tx_data  in  DATA_BITS  byte to send; captured in the same cycle as the accepted `tx_start`.
- tx_out  out  1  serial line, registered; idle level is 1.
- tx_busy  out  1  high from the cycle after acceptance until the frame completes.
- tx_done  out  1  one-cycle pulse when the stop bit finishes.

## Operation
- FSM states are IDLE, START, DATA and STOP.
  - IDLE -> START when `tx_start` = 1. `tx_data` is loaded into a shift register, the bit counter is cleared and the baud counter is cleared.
  - START -> DATA on `bit_tick`.
  - DATA -> DATA on `bit_tick` while bit_idx < DATA_BITS-1. The register shifts right and bit_idx increments.
  - DATA -> STOP on `bit_tick` with bit_idx = DATA_BITS-1.
  - STOP -> IDLE on `bit_tick`, and `tx_done` is set for the next cycle.
- `tx_out` per state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift_reg[0].
  - STOP: 1.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 while the FSM is not IDLE; held at 0 in IDLE.
  - `bit_tick` = (count == CLKS_PER_BIT-1). The counter wraps to 0 on the same edge.
- `tx_start` while `tx_busy` = 1 is ignored. `tx_data` changes while busy have no effect.
- `tx_busy` = (state != IDLE).
- Reset values: `tx_out` = 1, `tx_busy` = 0, `tx_done` = 0, state IDLE, counters 0, shift register 0.
- Reset mid-frame: the frame is aborted.
  - The line is high from the cycle after reset is sampled.
  - No `tx_done` is produced.
  - Reset has priority over `tx_start` in the same cycle.

## Timing
- `tx_start` accepted in cycle N:
  - `tx_out` goes to 0 in cycle N+1.
  - Bit k (k = 0..7) occupies cycles N+1+(k+1)·CLKS_PER_BIT through N+(k+2)·CLKS_PER_BIT.
  - The stop bit occupies cycles N+1+9·CLKS_PER_BIT through N+10·CLKS_PER_BIT.
- `tx_done` = 1 and `tx_busy` = 0 in cycle N+1+10·CLKS_PER_BIT. This is exactly one cycle, with the state already IDLE.
- A `tx_start` in the `tx_done` cycle is accepted. Back-to-back frames therefore have zero idle gap, and the next start bit begins at N+2+10·CLKS_PER_BIT.
- Total line time per frame is 10·CLKS_PER_BIT cycles. Start-to-start latency is 10·CLKS_PER_BIT+1 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP), shared with the RX FSM encoding style.
  - CLKS_PER_BIT_DEFAULT = 10416.
  - FRAME_BITS = 10.
  - LINE_IDLE = 1'b1.
- One sub-module, `tx_baud_counter`:
  - Inputs: `clk`, `tx_rst`, `enable`.
  - Output: `bit_tick`.
  - Parameter: CLKS_PER_BIT.
  - Mirrors the RX-side baud counter but counts a full bit period, with no 1.5-bit offset.
- Top level holds the FSM, the shift register and the 3-bit bit_idx.

## Test plan
- Reset, then idle for 50 cycles, with CLKS_PER_BIT=16 -> `tx_out` = 1, `tx_busy` = 0 and `tx_done` = 0 throughout.
- Send 8'hA5 with `tx_start` in cycle N, CLKS_PER_BIT=16 -> `tx_out` sequence per 16-cycle slot is 0,1,0,1,0,0,1,0,1,1. `tx_done` = 1 only at N+161.
- Back-to-back: 8'h00, then `tx_start` with 8'hFF in the `tx_done` cycle -> the second start bit begins at N+162 with no idle cycle. Two `tx_done` pulses occur, 161 cycles apart.
- `tx_start` with 8'h3C pulsed at cycle N+40 of an 8'h55 frame -> the frame is unchanged and exactly one `tx_done` is produced. The later byte is not sent.
- `tx_rst` asserted at N+70 mid-frame -> `tx_out` = 1 and `tx_busy` = 0 from N+71, no `tx_done`. A new `tx_start` with 8'h81 after reset sends a correct frame.
- Default CLKS_PER_BIT=10416 sending 8'h41 -> each bit is exactly 10416 cycles. `tx_done` is at N+104161. A loopback into the RX path decodes 8'h41.
